// File: rtl/stopwatch_if.sv
// Handshake bundle between the stopwatch control block and its neighbours:
// tick enables and debounced levels in, BCD digits, blank masks and state out.
interface stopwatch_if;
   logic       tick_1hz;
   logic       tick_2hz;
   logic       tick_blink;
   logic       rst_btn;
   logic       pause_btn;
   logic       adj;
   logic       sel;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       blank_min;
   logic       blank_sec;
   logic [1:0] state;

   modport master (
      output tick_1hz, tick_2hz, tick_blink, rst_btn, pause_btn, adj, sel,
      input  min_tens, min_ones, sec_tens, sec_ones, blank_min, blank_sec, state
   );

   modport slave (
      input  tick_1hz, tick_2hz, tick_blink, rst_btn, pause_btn, adj, sel,
      output min_tens, min_ones, sec_tens, sec_ones, blank_min, blank_sec, state
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: run/pause/adjust FSM, BCD mm:ss counter and blink masks.
// Everything runs on clk and advances only on the incoming tick enables.
module stopwatch_ctrl #(
   parameter int MAX_MIN = 99,
   parameter int MAX_SEC = 59
) (
   input  logic      clk,
   input  logic      rst,
   stopwatch_if.slave bus
);

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      PAUSED = 2'b01,
      ADJUST = 2'b10
   } state_t;

   localparam logic [7:0] MIN_LIM = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
   localparam logic [7:0] SEC_LIM = {4'(MAX_SEC / 10), 4'(MAX_SEC % 10)};

   state_t     cur;
   state_t     ret_state;
   logic       rst_btn_prev;
   logic       pause_btn_prev;
   logic       blink_phase;
   logic       blank_min_q;
   logic       blank_sec_q;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       clr_edge;
   logic       pause_edge;

   // BCD increment of a two-digit field, wrapping to 00 after lim.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
      if (v == lim)
         return 8'h00;
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'h0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   assign clr_edge   = bus.rst_btn   & ~rst_btn_prev;
   assign pause_edge = bus.pause_btn & ~pause_btn_prev;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cur            <= RUN;
         ret_state      <= RUN;
         rst_btn_prev   <= 1'b1;
         pause_btn_prev <= 1'b1;
         blink_phase    <= 1'b0;
         blank_min_q    <= 1'b0;
         blank_sec_q    <= 1'b0;
         min_bcd        <= 8'h00;
         sec_bcd        <= 8'h00;
      end else begin
         rst_btn_prev   <= bus.rst_btn;
         pause_btn_prev <= bus.pause_btn;
         blank_min_q    <= 1'b0;
         blank_sec_q    <= 1'b0;

         // Clear beats every tick; RUN carries seconds into minutes, ADJUST does not.
         if (clr_edge) begin
            min_bcd <= 8'h00;
            sec_bcd <= 8'h00;
         end else if (cur == RUN && bus.tick_1hz) begin
            sec_bcd <= bcd_inc(sec_bcd, SEC_LIM);
            if (sec_bcd == SEC_LIM)
               min_bcd <= bcd_inc(min_bcd, MIN_LIM);
         end else if (cur == ADJUST && bus.tick_2hz) begin
            if (bus.sel)
               sec_bcd <= bcd_inc(sec_bcd, SEC_LIM);
            else
               min_bcd <= bcd_inc(min_bcd, MIN_LIM);
         end

         case (cur)
            RUN: begin
               if (bus.adj) begin
                  cur         <= ADJUST;
                  ret_state   <= RUN;
                  blink_phase <= 1'b0;
               end else if (pause_edge && !clr_edge) begin
                  cur <= PAUSED;
               end
            end
            PAUSED: begin
               if (bus.adj) begin
                  cur         <= ADJUST;
                  ret_state   <= clr_edge ? RUN : PAUSED;
                  blink_phase <= 1'b0;
               end else if (clr_edge || pause_edge) begin
                  cur <= RUN;
               end
            end
            ADJUST: begin
               if (!bus.adj) begin
                  cur <= clr_edge ? RUN : ret_state;
               end else begin
                  blink_phase <= blink_phase ^ bus.tick_blink;
                  blank_min_q <= ~bus.sel & (blink_phase ^ bus.tick_blink);
                  blank_sec_q <=  bus.sel & (blink_phase ^ bus.tick_blink);
               end
            end
            default: cur <= RUN;
         endcase

         // A clear always makes the eventual return from ADJUST land in RUN.
         if (clr_edge)
            ret_state <= RUN;
      end
   end

   assign bus.min_tens  = min_bcd[7:4];
   assign bus.min_ones  = min_bcd[3:0];
   assign bus.sec_tens  = sec_bcd[7:4];
   assign bus.sec_ones  = sec_bcd[3:0];
   assign bus.blank_min = blank_min_q;
   assign bus.blank_sec = blank_sec_q;
   assign bus.state     = cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios then random
// stimulus, every cycle compared with an integer-arithmetic reference model.
module tb_stopwatch_ctrl;
   localparam int MAX_MIN = 99;
   localparam int MAX_SEC = 59;
   localparam int S_RUN = 0, S_PAUSED = 1, S_ADJUST = 2;

   logic clk = 1'b0;
   logic rst;
   stopwatch_if bus ();

   stopwatch_ctrl #(.MAX_MIN(MAX_MIN), .MAX_SEC(MAX_SEC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state: plain integers
   int m_state = S_RUN, m_ret = S_RUN, m_min = 0, m_sec = 0;
   bit m_blink = 0, m_bm = 0, m_bs = 0, m_prev_r = 1, m_prev_p = 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic int dut_mmss();
      return (int'(bus.min_tens) * 10 + int'(bus.min_ones)) * 100
           + int'(bus.sec_tens) * 10 + int'(bus.sec_ones);
   endfunction

   task automatic model_step();
      bit clr, pe;
      if (!rst) begin
         m_state = S_RUN; m_ret = S_RUN; m_min = 0; m_sec = 0;
         m_blink = 0; m_bm = 0; m_bs = 0; m_prev_r = 1; m_prev_p = 1;
         return;
      end
      clr = bus.rst_btn && !m_prev_r;
      pe  = bus.pause_btn && !m_prev_p;
      m_prev_r = bus.rst_btn;
      m_prev_p = bus.pause_btn;

      if (clr) begin
         m_min = 0; m_sec = 0;
      end else if (m_state == S_RUN && bus.tick_1hz) begin
         m_sec = (m_sec + 1) % (MAX_SEC + 1);
         if (m_sec == 0) m_min = (m_min + 1) % (MAX_MIN + 1);
      end else if (m_state == S_ADJUST && bus.tick_2hz) begin
         if (bus.sel) m_sec = (m_sec + 1) % (MAX_SEC + 1);
         else         m_min = (m_min + 1) % (MAX_MIN + 1);
      end

      if (m_state == S_RUN) begin
         if (bus.adj) begin m_state = S_ADJUST; m_ret = S_RUN; m_blink = 0; end
         else if (pe && !clr) m_state = S_PAUSED;
      end else if (m_state == S_PAUSED) begin
         if (bus.adj) begin m_state = S_ADJUST; m_ret = S_PAUSED; m_blink = 0; end
         else if (pe || clr) m_state = S_RUN;
      end else begin
         if (!bus.adj) m_state = clr ? S_RUN : m_ret;
         else if (bus.tick_blink) m_blink = !m_blink;
      end
      if (clr) m_ret = S_RUN;

      m_bm = (m_state == S_ADJUST) && !bus.sel && m_blink;
      m_bs = (m_state == S_ADJUST) &&  bus.sel && m_blink;
   endtask

   task automatic compare_all();
      check("state",     int'(bus.state),     m_state);
      check("min_tens",  int'(bus.min_tens),  m_min / 10);
      check("min_ones",  int'(bus.min_ones),  m_min % 10);
      check("sec_tens",  int'(bus.sec_tens),  m_sec / 10);
      check("sec_ones",  int'(bus.sec_ones),  m_sec % 10);
      check("blank_min", int'(bus.blank_min), int'(m_bm));
      check("blank_sec", int'(bus.blank_sec), int'(m_bs));
   endtask

   // One clock: model advances on the same inputs the DUT samples; pulses drop afterwards.
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      bus.tick_1hz   = 1'b0;
      bus.tick_2hz   = 1'b0;
      bus.tick_blink = 1'b0;
   endtask

   task automatic press_pause();
      bus.pause_btn = 1'b1; step();
      bus.pause_btn = 1'b0; step();
   endtask

   task automatic press_clear();
      bus.rst_btn = 1'b1; step();
      bus.rst_btn = 1'b0; step();
   endtask

   task automatic adj_ticks(input bit s, input int n);
      bus.sel = s;
      for (int i = 0; i < n; i++) begin
         bus.tick_2hz = 1'b1;
         step();
      end
   endtask

   task automatic tick1();
      bus.tick_1hz = 1'b1;
      step();
   endtask

   initial begin
      rst = 1'b0;
      bus.tick_1hz = 0; bus.tick_2hz = 0; bus.tick_blink = 0;
      bus.rst_btn = 1'b1; bus.pause_btn = 0; bus.adj = 0; bus.sel = 0;

      // reset with clear button held: no edge on release of reset
      repeat (3) step();
      check("rst_state", int'(bus.state), 0);
      check("rst_count", dut_mmss(), 0);
      rst = 1'b1;
      tick1(); tick1();
      check("held_no_clear", dut_mmss(), 2);
      bus.rst_btn = 1'b0; step();
      bus.rst_btn = 1'b1; step();
      check("second_press_clear", dut_mmss(), 0);
      bus.rst_btn = 1'b0; step();

      // preload 00:58, then carry into minutes
      bus.adj = 1'b1; bus.sel = 1'b1; step();
      adj_ticks(1'b1, 58);
      bus.adj = 1'b0; step();
      check("preload_0058", dut_mmss(), 58);
      tick1(); check("run_0059", dut_mmss(), 59);
      tick1(); check("run_0100", dut_mmss(), 100);
      tick1(); check("run_0101", dut_mmss(), 101);

      // preload 99:59 and wrap
      bus.adj = 1'b1; bus.sel = 1'b0; step();
      adj_ticks(1'b0, 98);
      adj_ticks(1'b1, 58);
      bus.adj = 1'b0; step();
      check("preload_9959", dut_mmss(), 9959);
      tick1(); check("wrap_0000", dut_mmss(), 0);

      // pause holds count, resume counts again
      press_pause();
      repeat (5) tick1();
      check("paused_hold", dut_mmss(), 0);
      check("paused_state", int'(bus.state), 1);
      press_pause();
      tick1();
      check("resumed_count", dut_mmss(), 1);
      check("resumed_state", int'(bus.state), 0);

      // adjust from PAUSED 12:34
      press_clear();
      press_pause();
      bus.adj = 1'b1; bus.sel = 1'b0; step();
      adj_ticks(1'b0, 12);
      adj_ticks(1'b1, 34);
      bus.adj = 1'b0; step();
      check("paused_1234", dut_mmss(), 1234);
      check("paused_1234_state", int'(bus.state), 1);
      bus.adj = 1'b1; bus.sel = 1'b1; step();
      adj_ticks(1'b1, 26);
      check("adj_sec_wrap", dut_mmss(), 1200);
      adj_ticks(1'b0, 88);
      check("adj_min_wrap", dut_mmss(), 0);
      bus.adj = 1'b0; step();
      check("adj_exit_paused", int'(bus.state), 1);

      // blink masks
      bus.adj = 1'b1; bus.sel = 1'b0; step();
      for (int i = 0; i < 3; i++) begin
         bus.tick_blink = 1'b1; step();
         check("blink_min", int'(bus.blank_min), (i % 2 == 0) ? 1 : 0);
         check("blink_sec", int'(bus.blank_sec), 0);
      end
      bus.adj = 1'b0; step();
      check("exit_blank_min", int'(bus.blank_min), 0);
      check("exit_blank_sec", int'(bus.blank_sec), 0);

      // clear coincident with tick and pause edge in RUN at 05:05
      press_pause();
      bus.adj = 1'b1; step();
      adj_ticks(1'b0, 5);
      adj_ticks(1'b1, 5);
      bus.adj = 1'b0; step();
      check("run_0505", dut_mmss(), 505);
      check("run_0505_state", int'(bus.state), 0);
      bus.rst_btn = 1'b1; bus.pause_btn = 1'b1; bus.tick_1hz = 1'b1; step();
      check("clr_prio_count", dut_mmss(), 0);
      check("clr_prio_state", int'(bus.state), 0);
      bus.rst_btn = 1'b0; bus.pause_btn = 1'b0; step();

      // random stimulus against the model
      for (int c = 0; c < 4000; c++) begin
         rst            = ($urandom_range(0, 499) != 0);
         bus.tick_1hz   = ($urandom_range(0, 3) == 0);
         bus.tick_2hz   = ($urandom_range(0, 3) == 0);
         bus.tick_blink = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 29) == 0) bus.rst_btn   = ~bus.rst_btn;
         if ($urandom_range(0, 9)  == 0) bus.pause_btn = ~bus.pause_btn;
         if ($urandom_range(0, 39) == 0) bus.adj       = ~bus.adj;
         if ($urandom_range(0, 19) == 0) bus.sel       = ~bus.sel;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control block for the stopwatch datapath. It turns debounced button/switch levels and one-cycle tick enables from the clock module into a run/pause/adjust state machine, and it owns the BCD minutes:seconds count. It also produces per-field blink masks for the seven-segment multiplexer. It sits between the debouncers/clock module and the display driver; all logic runs on the single system clock, gated by tick enables.

## Interface
- Parameters:
- `MAX_MIN`, default 99: highest minutes value before wrap.
- `MAX_SEC`, default 59: highest seconds value before wrap.
- Ports:
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  reset, synchronous and active-low.
- `tick_1hz`  in  1  one-`clk`-wide enable pulse at 1 Hz.
- `tick_2hz`  in  1  one-`clk`-wide enable pulse at 2 Hz.
- `tick_blink`  in  1  one-`clk`-wide enable pulse; the blink phase toggles on each pulse.
- `rst_btn`  in  1  debounced clear-button level.
- `pause_btn`  in  1  debounced pause-button level.
- `adj`  in  1  debounced adjust-switch level.
- `sel`  in  1  adjust field select: 0 = minutes, 1 = seconds.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD digits.
- `blank_min`, `blank_sec`  out  1 each  blank the digit pair this cycle.
- `state`  out  2  encoding: 00 RUN, 01 PAUSED, 10 ADJUST.

## Operation
- Button edge detection:
- Registered previous levels exist for `rst_btn` and `pause_btn`.
- Edge = level & ~prev.
- Both prev registers reset to 1, so a button held through reset produces no edge.
- `adj` and `sel` are used as levels.
- State machine. All decisions use the registered state from the start of the cycle.
- RUN:
- `pause_btn` edge -> PAUSED.
- `adj`=1 -> ADJUST, with `ret_state`=RUN.
- PAUSED:
- `pause_btn` edge -> RUN.
- `adj`=1 -> ADJUST, with `ret_state`=PAUSED.
- ADJUST:
- `adj`=0 -> `ret_state`.
- `pause_btn` edges are ignored.
- Counting in RUN, on `tick_1hz`:
- Seconds increment.
- At seconds = `MAX_SEC`, seconds go to 0 and minutes increment.
- At `MAX_MIN`:`MAX_SEC` the count wraps to 00:00.
- PAUSED: the count holds.
- ADJUST, on `tick_2hz`, the selected field increments by 1:
- Minutes wrap `MAX_MIN` -> 0.
- Seconds wrap `MAX_SEC` -> 0.
- No carry between fields; the unselected field holds.
- `tick_1hz` is ignored.
- Digits are stored and incremented as BCD.
- Ones digit 9 -> 0 with tens +1.
- No binary-to-BCD conversion.
- Clear:
- A `rst_btn` edge sets the count to 00:00, sets `ret_state`=RUN, and moves PAUSED -> RUN.
- An ADJUST state is kept; it exits to RUN.
- Clear has priority over every tick and over a same-cycle pause edge.
- Blink:
- `blink_phase` clears on entry to ADJUST.
- In ADJUST, `blink_phase` toggles on each `tick_blink`.
- `blank_min` = ADJUST & ~`sel` & `blink_phase`.
- `blank_sec` = ADJUST & `sel` & `blink_phase`.
- Both blank outputs are 0 outside ADJUST.
- Simultaneous events:
- Tick and pause edge in the same cycle in RUN: the increment happens, and PAUSED starts next cycle.
- `adj` rising and `tick_1hz` in the same cycle: the RUN increment happens, and ADJUST starts next cycle.
- `sel` changing mid-ADJUST takes effect on the next tick. `blink_phase` is not reset.

## Timing
- Reset (`rst`=0 at a `clk` edge):
- state = RUN, `ret_state` = RUN.
- All digits = 0, `blink_phase` = 0.
- `blank_*` = 0.
- prev registers = 1.
- All outputs are registered. Reset mid-operation overrides everything in that cycle.
- An input condition sampled at edge k is reflected on the outputs after edge k, i.e. one cycle of latency.
- Multiple ticks in consecutive cycles each take effect; no tick is dropped.

## Test plan
- Reset with `rst_btn`=1 held, then release and press again -> no clear on first release. Clear occurs only on the second press edge. Before that, digits are 0 and state=00.
- RUN from 00:58 with three `tick_1hz` -> 00:59, then 01:00, then 01:01. Preload 99:59 plus one tick -> 00:00.
- Pause edge, then 5 ticks -> count unchanged and state=01. Second pause edge plus one tick -> count +1 and state=00.
- From PAUSED 12:34, `adj`=1, `sel`=1, 26 `tick_2hz` -> 12:00 with minutes unchanged. `sel`=0 and 88 ticks -> 00:00. `adj`=0 -> state=01.
- ADJUST with `sel`=0, `tick_blink` x3 -> `blank_min` goes 1, 0, 1 and `blank_sec` stays 0. On exit, both are 0.
- `rst_btn` edge coincident with `tick_1hz` and a pause edge in RUN at 05:05 -> 00:00 next cycle and state=00.
